// File: rtl/fetch_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_stage_if
// Brief    : Fetch/decode handshake bundle. The instruction-memory port and the
//            IF/ID outputs are carried here, along with the stall and redirect inputs.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_decode_stage_if #(
  parameter int XLEN = 64
);
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [31:0]     imem_rdata;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     if_id_instr;
  logic [XLEN-1:0] if_id_pc;
  logic            if_id_valid;
  logic            halted;
  logic            fetch_misalign;
  logic [31:0]     fetch_count;
  logic [31:0]     stall_count;
  logic [31:0]     flush_count;

  modport slave (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid, halted,
           fetch_misalign, fetch_count, stall_count, flush_count
  );

  modport master (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid, halted,
           fetch_misalign, fetch_count, stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_stage
// Brief    : PC generation and IF/ID register with stall, flush and halt-on-ECALL.
//            Optional performance counters are enabled by IFID_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode_stage #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [31:0]     NOP_INSTR   = 32'h0000_0013,
  parameter logic [31:0]     ECALL_INSTR = 32'h0000_0073
) (
  input  wire                   clock,
  input  wire                   reset,
  fetch_decode_stage_if.slave   bus
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            misalign_q, misalign_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      ifpc_q     <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    misalign_d = 1'b0;

    if (bus.branch_taken) begin
      pc_d       = {bus.branch_target[XLEN-1:2], 2'b00};
      instr_d    = NOP_INSTR;
      ifpc_d     = '0;
      valid_d    = 1'b0;
      state_d    = S_RUN;
      halted_d   = 1'b0;
      misalign_d = (bus.branch_target[1:0] != 2'b00);
    end else if (state_q == S_HALT) begin
      // halted trails the state by one edge so the ECALL is seen valid first
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      halted_d = 1'b1;
    end else if (!bus.stall) begin
      instr_d = bus.imem_rdata;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + XLEN'(4);
      if (bus.imem_rdata == ECALL_INSTR) begin
        state_d = S_HALT;
      end
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc       = ifpc_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.halted         = halted_q;
  assign bus.fetch_misalign = misalign_q;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.branch_taken) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (state_q == S_RUN) begin
      if (bus.stall) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fetch_count = fetch_cnt_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;
`else
  assign bus.fetch_count = '0;
  assign bus.stall_count = '0;
  assign bus.flush_count = '0;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- PC generation plus IF/ID pipeline register, directly upstream of the decode/control stage.
- Drives the instruction-memory address and captures the returned word with its PC.
- Presents `if_id_instr`, `if_id_pc` and `if_id_valid` to decode; the opcode, func3/func7, register and immediate fields are sliced downstream.
- Handles hazard stall, branch flush and a halt-on-ECALL state machine.

Parameters:
- XLEN, 64, PC and address width.
- RESET_PC, 64'd0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).
- ECALL_INSTR, 32'h00000073, instruction word that triggers HALT.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from downstream (load-use); hold PC and IF/ID.
- branch_taken  in  1  redirect request from execute; flush IF/ID.
- branch_target  in  XLEN  redirect address.
- imem_rdata  in  32  instruction word for `imem_addr`; combinational memory, same-cycle data.
- imem_addr  out  XLEN  current PC; combinational from `pc_reg`.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc  out  XLEN  registered PC of `if_id_instr`.
- if_id_valid  out  1  1 = `if_id_instr` is a real instruction.
- halted  out  1  1 while FSM is in HALT.
- fetch_misalign  out  1  one-cycle pulse: `branch_target[1:0]` was nonzero.
- fetch_count  out  32  fetched-instruction counter (optional feature).
- stall_count  out  32  stall-cycle counter (optional feature).
- flush_count  out  32  flush counter (optional feature).

Behaviour:
- Reset values: `pc_reg` = RESET_PC; `if_id_instr` = NOP_INSTR; `if_id_pc` = 0; `if_id_valid` = 0; `halted` = 0; `fetch_misalign` = 0; counters = 0; FSM = RUN.
- Reset asserted mid-operation overrides all other inputs that cycle.
- FSM states:
  - RUN: normal fetch.
  - HALT: fetch frozen.
- Per-edge priority when not in reset: `branch_taken` > `stall` > normal advance.
- `branch_taken` = 1 (any state, overrides `stall`):
  - `pc_reg` <= {branch_target[XLEN-1:2], 2'b00}.
  - `if_id_instr` <= NOP_INSTR; `if_id_valid` <= 0; `if_id_pc` <= 0.
  - FSM <= RUN.
  - `fetch_misalign` <= (branch_target[1:0] != 0); otherwise `fetch_misalign` <= 0 every cycle.
- `stall` = 1, no branch: `pc_reg` and all `if_id_*` hold their values; FSM holds.
- Normal advance in RUN:
  - `if_id_instr` <= imem_rdata; `if_id_pc` <= pc_reg; `if_id_valid` <= 1.
  - `pc_reg` <= pc_reg + 4, modulo 2^XLEN; 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
  - If imem_rdata == ECALL_INSTR: ECALL is still latched valid; `pc_reg` stays at the ECALL address + 4; FSM <= HALT.
- HALT, no branch:
  - `pc_reg` holds.
  - `if_id_instr` <= NOP_INSTR; `if_id_valid` <= 0.
  - `stall` is ignored.
  - `halted` = 1 (registered; asserted the cycle after the ECALL is captured).
- Latency: `imem_addr` to `if_id_instr` is 1 cycle; redirect to first valid target instruction in IF/ID is 2 edges.
- `imem_addr` is always `pc_reg`, including during stall and HALT.

Optional Feature:
- Macro: `IFID_PERF_CNT_EN`.
- Defined:
  - `fetch_count` +1 on each normal advance.
  - `stall_count` +1 on each stall-hold cycle in RUN.
  - `flush_count` +1 on each `branch_taken` cycle.
  - All three wrap at 2^32 and clear on reset.
- Undefined: no counter registers; the three ports are tied to 0.

Test Plan:
- Reset, RESET_PC=0, memory returns addr-based words, 4 free cycles -> `if_id_pc` 0,4,8,12 with matching instr, `if_id_valid` = 1 from edge 1; `imem_addr` = 16.
- `stall` high 3 cycles at PC=8 -> `imem_addr` stays 8 and IF/ID holds PC 4 for 3 cycles; resumes with PC 8 after.
- `branch_taken` = 1 and `stall` = 1 simultaneously, target 0x100 -> next edge `imem_addr` = 0x100, `if_id_valid` = 0, instr = 0x00000013; following edge `if_id_pc` = 0x100.
- Target 0x102 -> `imem_addr` = 0x100, `fetch_misalign` pulses exactly 1 cycle.
- ECALL at PC 0x20 -> IF/ID holds 0x00000073 valid with pc 0x20; then `halted` = 1, bubbles, `imem_addr` frozen at 0x24; branch to 0x40 -> `halted` = 0, fetch resumes at 0x40.
- RESET_PC = 0xFFFF_FFFF_FFFF_FFFC, one advance -> `imem_addr` = 0. With `IFID_PERF_CNT_EN`: 5 fetches, 2 stalls, 1 flush -> counters 5/2/1; reset mid-run -> all counters 0 and `pc_reg` = RESET_PC next edge.
